serial_adder_nbits: RTL and testbench
=====================================

// Module: serial_adder_nbits
// PURPOSE
//   Bit-serial N-bit adder: Sum = A + B + Cin, one full-adder bit per clock, LSB first.
//   Single full-adder cell with a registered carry; start/busy/done handshake.
//   Area-cheap companion to the ripple subtractor datapath, for multi-cycle ALU
//   paths where latency is acceptable.
// PARAMETERS
//   WIDTH   4   operand/result width in bits (>= 2)
// PORTS
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous, active-low reset
//   start   in   1      request; sampled only when busy==0
//   A       in   WIDTH  addend, captured on the accepting edge
//   B       in   WIDTH  addend, captured on the accepting edge
//   Cin     in   1      carry-in, captured on the accepting edge
//   busy    out  1      high while a sum is in progress
//   done    out  1      one-cycle pulse: Sum/Cout just updated
//   Sum     out  WIDTH  registered result, held until the next completion
//   Cout    out  1      registered carry-out of bit WIDTH-1
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy, done, Cout = 0; Sum = 0;
//     internal shift regs, carry and bit counter = 0. Takes effect immediately,
//     including mid-operation; the aborted sum is discarded.
//   FSM: IDLE -> RUN on an edge with start=1. RUN -> IDLE after WIDTH bit edges.
//   Accept (edge k, IDLE, start=1): load A and B into shift regs, carry<=Cin, cnt<=0,
//     busy<=1. Inputs A, B and Cin are not looked at again until the next accept.
//   RUN (edges k+1 .. k+WIDTH): bit = a0^b0^carry;
//     carry <= a0&b0 | carry&(a0^b0); shift regs right by one;
//     bit enters result reg at the MSB; cnt++.
//   Completion (edge k+WIDTH, cnt==WIDTH-1): Sum<=final result, Cout<=final carry,
//     done<=1, busy<=0, state<=IDLE.
//   done stays high only during the cycle after edge k+WIDTH; it is cleared on the
//     next edge.
//   Latency: result valid WIDTH edges after the accept edge.
//   Throughput: one sum per WIDTH+1 edges, back-to-back.
//   Sum/Cout hold the previous result throughout RUN. They change only at completion.
//   start while busy=1: ignored, no queuing, no error.
//   start high during the done cycle (busy=0): accepted. done still drops on that edge.
//   Arithmetic is modulo 2^WIDTH. Cout is the true carry, so {Cout,Sum} = A+B+Cin.
//   Counter width: $clog2(WIDTH).
//   No X propagation: every register has a reset value.
// TESTING
//   T1: WIDTH=4, A=5, B=3, Cin=0, start one cycle -> busy for 4 cycles;
//       done at edge k+4; Sum=8, Cout=0.
//   T2: A=15, B=1, Cin=0 -> Sum=0, Cout=1.
//       A=7, B=8, Cin=1 -> Sum=0, Cout=1.
//       A=0, B=0, Cin=1 -> Sum=1, Cout=0.
//   T3: start 9+9, then at edge k+2 drive start=1 with A=1, B=1
//       -> ignored; Sum=2, Cout=1 (from 9+9); busy timing unchanged.
//   T4: start 6+6, assert rst_n=0 at k+2 (between edges) -> busy, done, Sum, Cout go
//       to 0 at once. After release, a fresh 3+4 -> Sum=7.
//   T5: hold start=1 with new operands in the done cycle -> second op accepted
//       immediately; done pulses exactly once per op.
//       Exhaustive compare against A+B+Cin for all 512 WIDTH=4 cases.
//   T6: WIDTH=8, A=200, B=100, Cin=0 -> done at edge k+8; Sum=44, Cout=1.

Source files
------------

// File: rtl/serial_adder_nbits.sv
// Bit-serial adder: one full-adder cell and a registered carry compute A+B+Cin,
// LSB first, over WIDTH clock edges after the start request is accepted.
module serial_adder_nbits #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] b_sh_next;

    // The sum bits enter b_sh at the MSB as its operand bits leave at the LSB,
    // so after WIDTH shifts b_sh holds the complete result.
    always_comb begin
        sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        b_sh_next  = {sum_bit, b_sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh_next;
                    carry <= carry_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        Sum   <= b_sh_next;
                        Cout  <= carry_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_nbits.sv
// Scoreboard bench for the bit-serial adder: WIDTH=4 instance for the main cases
// and exhaustive sweep, WIDTH=8 instance for the wide-operand case.
module tb_serial_adder_nbits;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [3:0] sum;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_issued = 0;
    int n_done = 0;

    typedef struct {
        logic [3:0] s;
        logic       c;
        int         due;
    } exp_t;
    exp_t sb[$];

    serial_adder_nbits #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Cin(cin),
        .busy(busy), .done(done), .Sum(sum), .Cout(cout)
    );

    serial_adder_nbits #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sum", {28'd0, sum}, {28'd0, e.s});
                chk("cout", {31'd0, cout}, {31'd0, e.c});
                chk("done_time", cyc, e.due);
                $display("op done: sum=%0d cout=%0d at cycle %0d", sum, cout, cyc);
            end
        end
    end

    // Drive one request on the first negedge where the adder is idle; the request
    // stays on the pins only for that one accepting edge.
    task automatic issue(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                         input bit expect_result);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("wait_idle_timeout", 1, 0);
        start = 1'b1; a = av; b = bv; cin = cv;
        if (expect_result) begin
            exp_t e;
            logic [4:0] full;
            full  = {1'b0, av} + {1'b0, bv} + {4'd0, cv};
            e.s   = full[3:0];
            e.c   = full[4];
            e.due = cyc + 1 + 4;
            sb.push_back(e);
            n_issued++;
        end
        $display("issue: A=%0d B=%0d Cin=%0d", av, bv, cv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("drain_timeout", 1, 0);
        @(negedge clk);
    endtask

    initial begin
        int k;
        int guard;

        #12;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_sum", {28'd0, sum}, 0);
        chk("rst_cout", {31'd0, cout}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: busy for exactly four cycles after the accepting edge.
        issue(4'd5, 4'd3, 1'b0, 1'b1);
        chk("t1_busy0", {31'd0, busy}, 1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t1_busy%0d", i), {31'd0, busy}, 1);
            chk("t1_sum_hold", {28'd0, sum}, 0);
        end
        @(negedge clk);
        chk("t1_busy_end", {31'd0, busy}, 0);
        drain();

        // T2
        issue(4'd15, 4'd1, 1'b0, 1'b1);
        issue(4'd7, 4'd8, 1'b1, 1'b1);
        issue(4'd0, 4'd0, 1'b1, 1'b1);
        drain();

        // T3: request while busy is ignored.
        issue(4'd9, 4'd9, 1'b0, 1'b1);
        start = 1'b1; a = 4'd1; b = 4'd1; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("t3_busy", {31'd0, busy}, 1);
        drain();
        chk("t3_idle", {31'd0, busy}, 0);

        // T4: asynchronous reset mid-operation discards the sum.
        issue(4'd6, 4'd6, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_busy", {31'd0, busy}, 0);
        chk("t4_done", {31'd0, done}, 0);
        chk("t4_sum", {28'd0, sum}, 0);
        chk("t4_cout", {31'd0, cout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd3, 4'd4, 1'b0, 1'b1);
        drain();

        // T5: exhaustive, back-to-back (each request lands in the previous done cycle).
        for (int i = 0; i < 512; i++) begin
            issue(i[3:0], i[7:4], i[8], 1'b1);
        end
        drain();
        chk("done_count", n_done, n_issued);

        // T6: WIDTH=8 instance.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0;
        k = cyc + 1;
        @(negedge clk);
        start8 = 1'b0;
        guard = 0;
        while (!done8 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("t6_done_seen", {31'd0, done8}, 1);
        chk("t6_done_time", cyc, k + 8);
        chk("t6_sum", {24'd0, sum8}, 44);
        chk("t6_cout", {31'd0, cout8}, 1);
        $display("op done (W=8): sum=%0d cout=%0d", sum8, cout8);
        @(negedge clk);
        chk("t6_done_pulse", {31'd0, done8}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
